// File: rtl/rgb_byte_demux.sv
// RGB byte demultiplexer: collects R, G, B bytes from a byte-serial link
// into 24-bit pixels on a registered valid/ready pixel interface, tagging
// the last pixel of each line and flagging sync-driven resynchronisation.
module rgb_byte_demux #(
    parameter int PIXELS_PER_LINE = 640,
    parameter int CNT_W           = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Buf,
    input  logic       buf_valid,
    output logic       buf_ready,
    input  logic       sync,
    output logic       SelR,
    output logic       SelG,
    output logic       SelB,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       eol,
    output logic       phase_err
);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    phase_t           phase_r;
    phase_t           phase_nxt_s;
    logic [7:0]       r_stage_r;
    logic [7:0]       g_stage_r;
    logic [7:0]       r_stage_nxt_s;
    logic [7:0]       g_stage_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       r_out_r;
    logic [7:0]       g_out_r;
    logic [7:0]       b_out_r;
    logic             pix_valid_r;
    logic             pix_valid_nxt_s;
    logic             eol_r;
    logic             err_r;
    logic             err_nxt_s;
    logic             load_s;
    logic             last_s;
    logic             accept_s;
    logic             buf_ready_s;

    // Only the completing B byte can stall, and only while the output
    // register still holds a pixel that downstream has not taken.
    assign buf_ready_s = !((phase_r == PH_B) && pix_valid_r && !pix_ready);
    assign accept_s    = buf_valid && buf_ready_s;
    assign last_s      = (cnt_r == CNT_W'(PIXELS_PER_LINE - 1));

    // Phase sequencing, staging capture, counter and resync detection.
    always_comb begin
        phase_nxt_s   = phase_r;
        r_stage_nxt_s = r_stage_r;
        g_stage_nxt_s = g_stage_r;
        cnt_nxt_s     = cnt_r;
        err_nxt_s     = 1'b0;
        load_s        = 1'b0;
        if (accept_s) begin
            if (sync) begin
                // A sync byte always starts a fresh pixel and line.
                r_stage_nxt_s = Buf;
                phase_nxt_s   = PH_G;
                cnt_nxt_s     = {CNT_W{1'b0}};
                err_nxt_s     = (phase_r != PH_R);
            end else begin
                case (phase_r)
                    PH_R: begin
                        r_stage_nxt_s = Buf;
                        phase_nxt_s   = PH_G;
                    end
                    PH_G: begin
                        g_stage_nxt_s = Buf;
                        phase_nxt_s   = PH_B;
                    end
                    PH_B: begin
                        load_s      = 1'b1;
                        phase_nxt_s = PH_R;
                        if (last_s) begin
                            cnt_nxt_s = {CNT_W{1'b0}};
                        end else begin
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        phase_nxt_s = PH_R;
                    end
                endcase
            end
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Output valid: a new load keeps it set (no bubble), otherwise a
    // downstream handshake clears it.
    always_comb begin
        pix_valid_nxt_s = pix_valid_r;
        if (load_s) begin
            pix_valid_nxt_s = 1'b1;
        end else if (pix_ready) begin
            pix_valid_nxt_s = 1'b0;
        end else begin
            pix_valid_nxt_s = pix_valid_r;
        end
    end

    // Control state: phase, staging, pixel counter, valid and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= PH_R;
            r_stage_r   <= 8'h00;
            g_stage_r   <= 8'h00;
            cnt_r       <= {CNT_W{1'b0}};
            pix_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            phase_r     <= phase_nxt_s;
            r_stage_r   <= r_stage_nxt_s;
            g_stage_r   <= g_stage_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pix_valid_r <= pix_valid_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // Pixel output register: loads on B completion, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_r <= 8'h00;
            g_out_r <= 8'h00;
            b_out_r <= 8'h00;
            eol_r   <= 1'b0;
        end else if (load_s) begin
            r_out_r <= r_stage_r;
            g_out_r <= g_stage_r;
            b_out_r <= Buf;
            eol_r   <= last_s;
        end else begin
            r_out_r <= r_out_r;
            g_out_r <= g_out_r;
            b_out_r <= b_out_r;
            eol_r   <= eol_r;
        end
    end

    assign buf_ready = buf_ready_s;
    assign SelR      = (phase_r == PH_R);
    assign SelG      = (phase_r == PH_G);
    assign SelB      = (phase_r == PH_B);
    assign R         = r_out_r;
    assign G         = g_out_r;
    assign B         = b_out_r;
    assign pix_valid = pix_valid_r;
    assign eol       = eol_r;
    assign phase_err = err_r;

endmodule

// File: doc/rgb_byte_demux.md
Name: rgb_byte_demux

Overview:
Receive-side counterpart of the RGB byte multiplexer. Accepts a stream of 8-bit colour bytes in R, G, B order on a valid/ready byte interface. Reassembles each triple into a 24-bit pixel and presents it on a registered valid/ready pixel interface, with end-of-line tagging. Sits between the byte-serial display link and the pixel pipeline.

Parameters:
PIXELS_PER_LINE, 640, pixels per line; drives the eol tag and the pixel counter wrap.
CNT_W, 10, pixel counter width; must satisfy 2^CNT_W >= PIXELS_PER_LINE.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
Buf  input  8  incoming colour byte.
buf_valid  input  1  Buf holds a valid byte.
buf_ready  output  1  block accepts Buf this cycle.
sync  input  1  qualifies Buf as the R byte of a new pixel; sampled only on accept.
SelR  output  1  next accepted byte is R (one-hot with SelG/SelB).
SelG  output  1  next accepted byte is G.
SelB  output  1  next accepted byte is B.
R  output  8  red component of the output pixel.
G  output  8  green component.
B  output  8  blue component.
pix_valid  output  1  R/G/B/eol hold a pixel.
pix_ready  input  1  downstream accepts the pixel.
eol  output  1  the output pixel is the last of its line.
phase_err  output  1  one-cycle pulse on a sync resynchronisation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - phase = PH_R, so SelR=1, SelG=0, SelB=0.
  - R/G/B = 0, staging registers = 0.
  - pix_valid=0, eol=0, phase_err=0, pixel counter=0.
  - buf_ready=1 after reset.
- Byte accept: a byte is accepted when buf_valid && buf_ready.
- Phase FSM (PH_R -> PH_G -> PH_B -> PH_R), advancing on accept only:
  - PH_R: Buf is captured into r_stage.
  - PH_G: Buf is captured into g_stage.
  - PH_B: r_stage, g_stage and Buf are loaded into R/G/B. pix_valid=1 on the next cycle. eol is loaded at the same time.
- Sel outputs: SelR/SelG/SelB decode the phase register directly and are always exactly one-hot.
- Backpressure:
  - buf_ready = !(phase==PH_B && pix_valid && !pix_ready). Only the completing B byte stalls.
  - R and G bytes are always accepted.
- Throughput and latency:
  - Sustained throughput is 1 pixel per 3 accepted bytes.
  - The pixel is visible on the cycle after the B byte is accepted.
- Output register:
  - pix_valid clears on pix_ready when no new pixel is loaded in the same cycle.
  - Simultaneous pixel handoff and B-byte accept: the new pixel loads and pix_valid stays 1, with no bubble.
  - R/G/B/eol hold stable while pix_valid && !pix_ready.
- sync handling, on accept with sync=1:
  - The byte is always treated as R: captured into r_stage, and phase goes to PH_G.
  - If the phase was not PH_R, any partial pixel is discarded, phase_err pulses 1 the next cycle, and the pixel counter resets to 0.
  - If the phase was PH_R, the pixel counter resets to 0 and phase_err stays 0.
  - sync without accept is ignored.
- Pixel counter and eol:
  - The counter increments when a pixel is loaded into the output register.
  - eol=1 for the loaded pixel when the count equals PIXELS_PER_LINE-1. The counter then wraps to 0.
- Reset mid-pixel: partial bytes are dropped immediately, and any pending output pixel is lost (pix_valid=0).
- buf_valid deasserting mid-pixel: the phase and staging registers are held indefinitely; there is no timeout.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33 with pix_ready=1 -> SelR/SelG/SelB step R,G,B; next cycle pix_valid=1, R=0x11, G=0x22, B=0x33; SelR=1 again.
- Continuous byte stream, pix_ready=1, PIXELS_PER_LINE=4, 15 bytes -> 5 pixels; eol=1 only on pixel 4; counter wraps; pixel 5 has eol=0.
- pix_ready=0 with one pixel held, then feed R,G,B -> R,G accepted, buf_ready=0 on the B byte; held pixel stays stable; raising pix_ready loads the new pixel with no gap in pix_valid.
- Feed 0xAA (R), 0xBB (G), then 0xCC with sync=1 -> phase_err pulses once; 0xCC becomes R; next 0xDD,0xEE produce pixel CC/DD/EE; counter restarts at 0.
- Assert rst_n=0 asynchronously after the G byte with a pixel pending -> pix_valid, R/G/B and eol go to 0 immediately; SelR=1; next triple assembles correctly.
- buf_valid gaps of 1–5 cycles between bytes -> identical pixel contents and order as gap-free run; no spurious pix_valid.
